// File: rtl/branch_resolve_ex.sv
// branch_resolve_ex: D->E control-flow register, Execute-stage branch resolution,
// and a saturating count of taken redirects.
`default_nettype none

module branch_resolve_ex #(
    parameter int IW = 20,
    parameter int AW = 15,
    parameter int DW = 20,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] InstrD,
    input  logic [AW-1:0] PCD,
    input  logic [AW-1:0] PCPlus1D,
    input  logic          FlushE,
    input  logic [DW-1:0] RD1E,
    input  logic [DW-1:0] RD2E,
    output logic          PCSrcE,
    output logic [AW-1:0] PCTargetE,
    output logic          FlushD,
    output logic [IW-1:0] InstrE,
    output logic [AW-1:0] PCPlus1E,
    output logic          ValidE,
    output logic [CW-1:0] TakenCount
);

    localparam logic [3:0] c_OP_B   = 4'hA;
    localparam logic [3:0] c_OP_BEQ = 4'hB;
    localparam logic [3:0] c_OP_BNE = 4'hC;
    localparam logic [3:0] c_OP_BLT = 4'hD;
    localparam logic [3:0] c_OP_JAL = 4'hE;

    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_pc_plus1;
    logic          r_valid;
    logic [CW-1:0] r_taken_cnt;

    logic [3:0]    w_opcode;
    logic [AW-1:0] w_imm_sext;
    logic          w_cond;
    logic          w_taken;

    assign w_opcode   = r_instr[IW-1 -: 4];
    assign w_imm_sext = {{(AW-12){r_instr[11]}}, r_instr[11:0]};

    always_comb begin
        w_cond = 1'b0;
        unique case (w_opcode)
            c_OP_B,
            c_OP_JAL: w_cond = 1'b1;
            c_OP_BEQ: w_cond = (RD1E == RD2E);
            c_OP_BNE: w_cond = (RD1E != RD2E);
            c_OP_BLT: w_cond = ($signed(RD1E) < $signed(RD2E));
            default:  w_cond = 1'b0;
        endcase
    end

    assign w_taken = r_valid & w_cond;

    // A taken branch bubbles the wrong-path instruction now sitting in Decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr    <= '0;
            r_pc       <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (FlushE || w_taken) begin
            r_instr    <= '0;
            r_pc       <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_instr    <= InstrD;
            r_pc       <= PCD;
            r_pc_plus1 <= PCPlus1D;
            r_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_taken_cnt <= '0;
        end else if (w_taken && (r_taken_cnt != {CW{1'b1}})) begin
            r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end

    assign PCSrcE     = w_taken;
    assign FlushD     = w_taken;
    assign PCTargetE  = r_pc + w_imm_sext;
    assign InstrE     = r_instr;
    assign PCPlus1E   = r_pc_plus1;
    assign ValidE     = r_valid;
    assign TakenCount = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ex.sv
// tb_branch_resolve_ex: directed vectors with hand-computed expectations for branch_resolve_ex.
`default_nettype none

module tb_branch_resolve_ex;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] InstrD;
    logic [14:0] PCD;
    logic [14:0] PCPlus1D;
    logic        FlushE;
    logic [19:0] RD1E;
    logic [19:0] RD2E;

    logic        PCSrcE;
    logic [14:0] PCTargetE;
    logic        FlushD;
    logic [19:0] InstrE;
    logic [14:0] PCPlus1E;
    logic        ValidE;
    logic [15:0] TakenCount;

    logic        s_PCSrcE;
    logic [14:0] s_PCTargetE;
    logic        s_FlushD;
    logic [19:0] s_InstrE;
    logic [14:0] s_PCPlus1E;
    logic        s_ValidE;
    logic [1:0]  s_TakenCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_ex dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus1D(PCPlus1D),
        .FlushE(FlushE), .RD1E(RD1E), .RD2E(RD2E), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .FlushD(FlushD), .InstrE(InstrE), .PCPlus1E(PCPlus1E), .ValidE(ValidE),
        .TakenCount(TakenCount)
    );

    // Narrow counter instance so saturation is reachable in a few branches.
    branch_resolve_ex #(.CW(2)) dut_sat (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus1D(PCPlus1D),
        .FlushE(FlushE), .RD1E(RD1E), .RD2E(RD2E), .PCSrcE(s_PCSrcE), .PCTargetE(s_PCTargetE),
        .FlushD(s_FlushD), .InstrE(s_InstrE), .PCPlus1E(s_PCPlus1E), .ValidE(s_ValidE),
        .TakenCount(s_TakenCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [19:0] instr, input logic [14:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus1D = pc + 15'd1;
    endtask

    initial begin
        reset  = 1'b0;
        FlushE = 1'b0;
        RD1E   = 20'h00007;
        RD2E   = 20'h00007;
        drive(20'hB0000, 15'h0005);

        // Reset held with a taken-looking BEQ in Decode
        tick();
        chk("rst1_pcsrc", 32'(PCSrcE), 32'd0);
        chk("rst1_valid", 32'(ValidE), 32'd0);
        chk("rst1_cnt", 32'(TakenCount), 32'd0);
        tick();
        chk("rst2_pcsrc", 32'(PCSrcE), 32'd0);
        chk("rst2_valid", 32'(ValidE), 32'd0);
        chk("rst2_cnt", 32'(TakenCount), 32'd0);
        chk("rst2_target", 32'(PCTargetE), 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_valid", 32'(ValidE), 32'd1);
        chk("post_rst_pcsrc", 32'(PCSrcE), 32'd1);
        chk("post_rst_target", 32'(PCTargetE), 32'h0005);
        drive(20'h00000, 15'h0006);
        tick();
        chk("post_rst_bubble", 32'(ValidE), 32'd0);
        chk("post_rst_cnt", 32'(TakenCount), 32'd1);

        // B +5 from 0x0010
        drive(20'hA0005, 15'h0010);
        tick();
        chk("b_pcsrc", 32'(PCSrcE), 32'd1);
        chk("b_target", 32'(PCTargetE), 32'h0015);
        chk("b_flushd", 32'(FlushD), 32'd1);
        chk("b_instre", 32'(InstrE), 32'hA0005);
        chk("b_pcplus1e", 32'(PCPlus1E), 32'h0011);
        drive(20'h00000, 15'h0011);
        tick();
        chk("b_bubble_valid", 32'(ValidE), 32'd0);
        chk("b_bubble_pcsrc", 32'(PCSrcE), 32'd0);
        chk("b_bubble_instr", 32'(InstrE), 32'd0);
        chk("b_cnt", 32'(TakenCount), 32'd2);
        tick();
        chk("nop_valid", 32'(ValidE), 32'd1);
        chk("nop_pcsrc", 32'(PCSrcE), 32'd0);

        // BEQ -4 from 0x0003 wraps low
        RD1E = 20'h12345;
        RD2E = 20'h12345;
        drive(20'hB0FFC, 15'h0003);
        tick();
        chk("beq_pcsrc", 32'(PCSrcE), 32'd1);
        chk("beq_target", 32'(PCTargetE), 32'h7FFF);
        drive(20'h00000, 15'h0004);
        tick();
        chk("beq_cnt", 32'(TakenCount), 32'd3);
        RD2E = 20'h12344;
        drive(20'hB0FFC, 15'h0003);
        tick();
        chk("beq_nt_pcsrc", 32'(PCSrcE), 32'd0);
        chk("beq_nt_valid", 32'(ValidE), 32'd1);
        chk("beq_nt_flushd", 32'(FlushD), 32'd0);

        // BNE +2 from 0x7FFE wraps high
        drive(20'hC0002, 15'h7FFE);
        tick();
        chk("bne_pcsrc", 32'(PCSrcE), 32'd1);
        chk("bne_target", 32'(PCTargetE), 32'h0000);
        drive(20'h00000, 15'h0001);
        tick();
        chk("bne_cnt", 32'(TakenCount), 32'd4);

        // BLT signed compare
        RD1E = 20'h80000;
        RD2E = 20'h00001;
        drive(20'hD0001, 15'h0020);
        tick();
        chk("blt_pcsrc", 32'(PCSrcE), 32'd1);
        chk("blt_target", 32'(PCTargetE), 32'h0021);
        drive(20'h00000, 15'h0021);
        tick();
        RD1E = 20'h00001;
        RD2E = 20'h80000;
        drive(20'hD0001, 15'h0020);
        tick();
        chk("blt_swap_pcsrc", 32'(PCSrcE), 32'd0);
        chk("blt_cnt", 32'(TakenCount), 32'd5);

        // JAL ignores operands and exposes its link value
        drive(20'hE0010, 15'h0100);
        tick();
        chk("jal_pcsrc", 32'(PCSrcE), 32'd1);
        chk("jal_target", 32'(PCTargetE), 32'h0110);
        chk("jal_link", 32'(PCPlus1E), 32'h0101);
        drive(20'h00000, 15'h0101);
        tick();

        // Non-branch opcode with equal operands is never taken
        RD1E = 20'h00042;
        RD2E = 20'h00042;
        drive(20'hF0003, 15'h0200);
        tick();
        chk("other_pcsrc", 32'(PCSrcE), 32'd0);
        chk("other_valid", 32'(ValidE), 32'd1);
        chk("other_cnt", 32'(TakenCount), 32'd6);

        // External flush squashes a taken B before it reaches Execute
        FlushE = 1'b1;
        drive(20'hA0005, 15'h0300);
        tick();
        FlushE = 1'b0;
        chk("flushe_instr", 32'(InstrE), 32'd0);
        chk("flushe_valid", 32'(ValidE), 32'd0);
        chk("flushe_pcsrc", 32'(PCSrcE), 32'd0);
        chk("flushe_cnt", 32'(TakenCount), 32'd6);

        // FlushE together with a redirect yields a single bubble
        tick();
        chk("both_pcsrc", 32'(PCSrcE), 32'd1);
        FlushE = 1'b1;
        drive(20'h00000, 15'h0301);
        tick();
        FlushE = 1'b0;
        chk("both_valid", 32'(ValidE), 32'd0);
        chk("both_cnt", 32'(TakenCount), 32'd7);
        tick();
        chk("both_after_valid", 32'(ValidE), 32'd1);

        // Asynchronous reset in the middle of a redirect
        drive(20'hA0004, 15'h0400);
        tick();
        chk("mid_pcsrc", 32'(PCSrcE), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pcsrc", 32'(PCSrcE), 32'd0);
        chk("mid_rst_flushd", 32'(FlushD), 32'd0);
        chk("mid_rst_instr", 32'(InstrE), 32'd0);
        chk("mid_rst_cnt", 32'(TakenCount), 32'd0);
        chk("mid_rst_target", 32'(PCTargetE), 32'd0);
        #1 reset = 1'b1;

        // Saturation: five taken B's on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            drive(20'hA0001, 15'h0500);
            tick();
            drive(20'h00000, 15'h0501);
            tick();
            chk("sat_wide_cnt", 32'(TakenCount), 32'(i + 1));
            chk("sat_narrow_cnt", 32'(s_TakenCount), (i < 3) ? 32'(i + 1) : 32'd3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
